axi_sram_512x45: RTL and testbench

Single-port 512-word on-chip SRAM behind an AXI4-Lite slave interface; it serves as the boot and program memory of the CPU subsystem. The storage macro holds 45-bit words, of which bits [31:0] carry data. Word 0 sits at byte address 0x000. The macro array is directly addressable by hierarchical backdoor for firmware preload.

---
 rtl/axi_sram_pkg.sv | 40 ++++
 rtl/sram_512x45.sv | 30 +++
 rtl/axi_sram_512x45.sv | 108 ++++++++++
 tb/tb_axi_sram_512x45.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_pkg.sv
// Geometry, AXI response codes and address-slicing helpers shared by the 512x45 SRAM slice.
package axi_sram_pkg;

    localparam int SRAM_DEPTH = 512;
    localparam int SRAM_WIDTH = 45;
    localparam int SRAM_ROWS  = 128;
    localparam int SRAM_COLS  = 4;
    localparam int DATA_W     = 32;
    localparam int IDX_W      = $clog2(SRAM_DEPTH);
    localparam int ROW_W      = $clog2(SRAM_ROWS);
    localparam int COL_W      = $clog2(SRAM_COLS);

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_e;

    // Byte address -> word; bits [1:0] and [31:11] are don't-care, so the map aliases every 2 KiB.
    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return addr[10:2];
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [31:0] addr);
        return addr[10:4];
    endfunction

    function automatic logic [COL_W-1:0] col_of(input logic [31:0] addr);
        return addr[3:2];
    endfunction

    function automatic logic [3:0] byte_parity(input logic [DATA_W-1:0] data);
        logic [3:0] p;
        p = '0;
        for (int n = 0; n < 4; n++) begin
            p[n] = ^data[8*n +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/sram_512x45.sv
// Synchronous single-port 128x4 macro model of 45-bit words with a per-bit write mask.
module sram_512x45
    import axi_sram_pkg::*;
(
    input  logic                  clk,
    input  logic                  cs,
    input  logic                  we,
    input  logic [SRAM_WIDTH-1:0] wmask,
    input  logic [ROW_W-1:0]      row,
    input  logic [COL_W-1:0]      col,
    input  logic [SRAM_WIDTH-1:0] din,
    output logic [SRAM_WIDTH-1:0] dout
);

    // Named in capitals because firmware preload reaches it by hierarchical path.
    logic [SRAM_WIDTH-1:0] MEMORY [0:SRAM_ROWS-1][0:SRAM_COLS-1];

    // NOTE: the array and its output register carry no reset; a macro has no reset port and
    //       clearing 512 words would need a sequencer, so contents survive a logic reset.
    always_ff @(posedge clk) begin
        if (cs) begin
            if (we) begin
                MEMORY[row][col] <= (MEMORY[row][col] & ~wmask) | (din & wmask);
            end else begin
                dout <= MEMORY[row][col];
            end
        end
    end

endmodule

// File: rtl/axi_sram_512x45.sv
// AXI4-Lite slave wrapper around the 512x45 boot/program SRAM; write wins over read in a tie.
// Define AXI_SRAM_PARITY_EN to store per-byte even parity in bits [35:32] and flag SLVERR on read.
module axi_sram_512x45
    import axi_sram_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] axi_awaddr,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    input  logic [31:0] axi_araddr,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready
);

    logic                  bvalid_q, bvalid_d;
    logic                  rvalid_q, rvalid_d;
    logic                  wr_go, rd_go;
    logic [ROW_W-1:0]      mem_row;
    logic [COL_W-1:0]      mem_col;
    logic [SRAM_WIDTH-1:0] mem_din, mem_wmask, mem_dout;
    logic                  rd_err;
    logic                  unused_dout;
    logic                  unused_addr;

    always_comb begin
        // NOTE: each always_comb target is given a default before any branch, so no latch is inferred.
        wr_go    = !aresetn && axi_awvalid && axi_wvalid && !bvalid_q;
        rd_go    = !aresetn && axi_arvalid && !rvalid_q && !wr_go;
        bvalid_d = bvalid_q;
        rvalid_d = rvalid_q;
        if (bvalid_q && axi_bready) bvalid_d = 1'b0;
        if (wr_go)                  bvalid_d = 1'b1;
        if (rvalid_q && axi_rready) rvalid_d = 1'b0;
        if (rd_go)                  rvalid_d = 1'b1;
    end

    always_comb begin
        mem_row        = wr_go ? row_of(axi_awaddr) : row_of(axi_araddr);
        mem_col        = wr_go ? col_of(axi_awaddr) : col_of(axi_araddr);
        mem_din        = '0;
        mem_din[31:0]  = axi_wdata;
        mem_wmask      = '0;
        for (int n = 0; n < 4; n++) begin
            mem_wmask[8*n +: 8] = {8{axi_wstrb[n]}};
        end
`ifdef AXI_SRAM_PARITY_EN
        mem_din[35:32]   = byte_parity(axi_wdata);
        mem_wmask[35:32] = axi_wstrb;
        mem_wmask[44:36] = {9{|axi_wstrb}};
`else
        mem_wmask[44:32] = {13{|axi_wstrb}};
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            bvalid_q <= bvalid_d;
            rvalid_q <= rvalid_d;
        end
    end

    sram_512x45 u_sram_512x45 (
        .clk   (aclk),
        .cs    (wr_go || rd_go),
        .we    (wr_go),
        .wmask (mem_wmask),
        .row   (mem_row),
        .col   (mem_col),
        .din   (mem_din),
        .dout  (mem_dout)
    );

`ifdef AXI_SRAM_PARITY_EN
    assign rd_err      = |(byte_parity(mem_dout[31:0]) ^ mem_dout[35:32]);
    assign unused_dout = ^mem_dout[44:36];
`else
    assign rd_err      = 1'b0;
    assign unused_dout = ^mem_dout[44:32];
`endif
    assign unused_addr = ^{axi_awaddr[31:11], axi_awaddr[1:0], axi_araddr[31:11], axi_araddr[1:0]};

    // Macro output only moves on an accepted read, so gating with rvalid keeps rdata 0 out of reset.
    assign axi_awready = wr_go;
    assign axi_wready  = wr_go;
    assign axi_arready = rd_go;
    assign axi_bvalid  = bvalid_q;
    assign axi_bresp   = OKAY;
    assign axi_rvalid  = rvalid_q;
    assign axi_rdata   = rvalid_q ? mem_dout[31:0] : '0;
    assign axi_rresp   = (rvalid_q && rd_err) ? SLVERR : OKAY;

endmodule

// File: tb/tb_axi_sram_512x45.sv
// Randomized self-checking bench for axi_sram_512x45 against a word-array reference model.
module tb_axi_sram_512x45;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] awaddr, wdata, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    logic [31:0] model [0:511];
    int          n_tests = 0;
    int          n_fail  = 0;

`ifdef AXI_SRAM_PARITY_EN
    localparam logic [1:0] FLIP_RESP = 2'b10;
`else
    localparam logic [1:0] FLIP_RESP = 2'b00;
`endif

    always #5 aclk = ~aclk;

    axi_sram_512x45 dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .axi_awaddr  (awaddr),
        .axi_awvalid (awvalid),
        .axi_awready (awready),
        .axi_wdata   (wdata),
        .axi_wstrb   (wstrb),
        .axi_wvalid  (wvalid),
        .axi_wready  (wready),
        .axi_bresp   (bresp),
        .axi_bvalid  (bvalid),
        .axi_bready  (bready),
        .axi_araddr  (araddr),
        .axi_arvalid (arvalid),
        .axi_arready (arready),
        .axi_rdata   (rdata),
        .axi_rresp   (rresp),
        .axi_rvalid  (rvalid),
        .axi_rready  (rready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int n = 0; n < 4; n++) begin
            if (strb[n]) r[8*n +: 8] = data[8*n +: 8];
        end
        return r;
    endfunction

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        logic [44:0] w;
        w = {13'b0, data};
`ifdef AXI_SRAM_PARITY_EN
        for (int n = 0; n < 4; n++) w[32+n] = ^data[8*n +: 8];
`endif
        dut.u_sram_512x45.MEMORY[addr[10:4]][addr[3:2]] = w;
        model[addr[10:2]] = data;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int b_delay);
        @(negedge aclk);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        for (int i = 0; i < 20 && !awready; i++) begin
            @(negedge aclk); #1;
        end
        check("awready", 32'(awready), 32'd1);
        check("wready", 32'(wready), 32'd1);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        model[addr[10:2]] = merge(model[addr[10:2]], data, strb);
        check("bvalid_after_hs", 32'(bvalid), 32'd1);
        check("bresp", 32'(bresp), 32'd0);
        for (int i = 0; i < b_delay; i++) begin
            @(posedge aclk); #1;
            check("bvalid_hold", 32'(bvalid), 32'd1);
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        check("bvalid_drop", 32'(bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_delay, input logic [1:0] exp_resp);
        logic [31:0] exp;
        @(negedge aclk);
        araddr = addr; arvalid = 1'b1;
        #1;
        for (int i = 0; i < 20 && !arready; i++) begin
            @(negedge aclk); #1;
        end
        check("arready", 32'(arready), 32'd1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        exp = model[addr[10:2]];
        check("rvalid_after_hs", 32'(rvalid), 32'd1);
        check("rdata", rdata, exp);
        check("rresp", 32'(rresp), 32'(exp_resp));
        for (int i = 0; i < r_delay; i++) begin
            @(posedge aclk); #1;
            check("rvalid_hold", 32'(rvalid), 32'd1);
            check("rdata_hold", rdata, exp);
        end
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        check("rvalid_drop", 32'(rvalid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tmp, d;
        logic [8:0]  idx;
        aresetn = 1'b1;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;

        for (int r = 0; r < 128; r++) begin
            for (int c = 0; c < 4; c++) begin
                preload(32'(r * 16 + c * 4), $urandom());
            end
        end

        // Valids held high through reset must not be accepted.
        repeat (3) @(posedge aclk);
        @(negedge aclk); #1;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        check("rst_rresp", 32'(rresp), 32'd0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        aresetn = 1'b0;

        preload(32'h000, 32'h0000_0013);
        axi_read(32'h000, 0, 2'b00);

        axi_write(32'h104, 32'hDEAD_BEEF, 4'hF, 0);
        axi_read(32'h104, 0, 2'b00);
        axi_write(32'h104, 32'h1122_3344, 4'b0101, 1);
        axi_read(32'h104, 0, 2'b00);
        axi_write(32'h104, 32'hFFFF_FFFF, 4'h0, 0);
        axi_read(32'h104, 0, 2'b00);

        // Write/read tie on the same word: write goes first, read sees new data.
        d = $urandom();
        @(negedge aclk);
        awaddr = 32'h10C; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h10C; arvalid = 1'b1;
        #1;
        check("coll_awready", 32'(awready), 32'd1);
        check("coll_arready_blocked", 32'(arready), 32'd0);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        model[32'h10C >> 2] = d;
        check("coll_bvalid", 32'(bvalid), 32'd1);
        check("coll_arready_next", 32'(arready), 32'd1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        check("coll_rvalid", 32'(rvalid), 32'd1);
        check("coll_rdata", rdata, d);
        bready = 1'b1; rready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0; rready = 1'b0;
        check("coll_bvalid_drop", 32'(bvalid), 32'd0);
        check("coll_rvalid_drop", 32'(rvalid), 32'd0);

        axi_read(32'h104, 5, 2'b00);
        axi_read(32'h904, 0, 2'b00);

        // Reset with a write response pending: bvalid clears, data stays committed.
        d = $urandom();
        @(negedge aclk);
        awaddr = 32'h208; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        check("rstw_awready", 32'(awready), 32'd1);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        model[32'h208 >> 2] = d;
        check("rstw_bvalid", 32'(bvalid), 32'd1);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        aresetn = 1'b0;
        check("rstw_bvalid_cleared", 32'(bvalid), 32'd0);
        axi_read(32'h208, 0, 2'b00);

        // Reset with a read response pending.
        @(negedge aclk);
        araddr = 32'h208; arvalid = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        check("rstr_rvalid", 32'(rvalid), 32'd1);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        aresetn = 1'b0;
        check("rstr_rvalid_cleared", 32'(rvalid), 32'd0);
        check("rstr_rdata_cleared", rdata, 32'd0);

        // Corrupt bit 32 behind the interface; only the parity build reports it.
        dut.u_sram_512x45.MEMORY[16][1][32] = ~dut.u_sram_512x45.MEMORY[16][1][32];
        axi_read(32'h104, 0, FLIP_RESP);
        axi_write(32'h104, $urandom(), 4'hF, 0);
        axi_read(32'h104, 0, 2'b00);

        for (int k = 0; k < 80; k++) begin
            tmp = $urandom();
            if (k % 4 == 0) idx = 9'($urandom_range(0, 511));
            else            idx = 9'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                axi_write({tmp[31:11], idx, tmp[1:0]}, $urandom(), 4'($urandom_range(0, 15)),
                          $urandom_range(0, 2));
            end else begin
                axi_read({tmp[31:11], idx, tmp[1:0]}, $urandom_range(0, 3), 2'b00);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
